// File: rtl/syn_updown_counter_mod.sv
// Parametrised synchronous up/down counter with load, wrap or saturate at the
// bounds, a combinational terminal count for cascading and registered pulse flags.
module syn_updown_counter_mod #(
  parameter int               WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic at_max;
  logic at_zero;

  assign at_max  = (Q == MAX);
  assign at_zero = (Q == '0);

  // tc is exactly the "this enabled edge hits a bound" condition, so it also drives ovf
  assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

  always_ff @(posedge clk) begin
    if (reset) begin
      Q        <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      ovf <= 1'b0;
      if (load_val > MAX) begin
        Q        <= MAX;
        load_err <= 1'b1;
      end else begin
        Q        <= load_val;
        load_err <= 1'b0;
      end
    end else begin
      load_err <= 1'b0;
      ovf      <= tc;
      if (en) begin
        if (up_dn) begin
          if (!at_max)
            Q <= Q + WIDTH'(1);
          else if (!SATURATE)
            Q <= '0;
        end else begin
          if (!at_zero)
            Q <= Q - WIDTH'(1);
          else if (!SATURATE)
            Q <= MAX;
        end
      end
    end
  end

endmodule

// File: tb/tb_syn_updown_counter_mod.sv
// Bench for syn_updown_counter_mod: a wrapping MODULUS=10 and a saturating MODULUS=16
// instance share stimulus against an arithmetic model; a two-digit cascade is checked too.
module tb_syn_updown_counter_mod;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;

  logic [3:0] a_q, b_q;
  logic       a_tc, a_ovf, a_lerr, b_tc, b_ovf, b_lerr;

  logic       c_reset, c_en;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_ovf, c0_lerr, c1_tc, c1_ovf, c1_lerr;

  int checks = 0;
  int errors = 0;
  int qa = 0, qb = 0;
  bit oa, ob, la, lb;
  bit started = 1'b0;

  always #5 clk = ~clk;

  syn_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .Q(a_q), .tc(a_tc), .ovf(a_ovf), .load_err(a_lerr));

  syn_updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .Q(b_q), .tc(b_tc), .ovf(b_ovf), .load_err(b_lerr));

  syn_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_c0 (
    .clk(clk), .reset(c_reset), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .Q(c0_q), .tc(c0_tc), .ovf(c0_ovf), .load_err(c0_lerr));

  syn_updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_c1 (
    .clk(clk), .reset(c_reset), .en(c0_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .Q(c1_q), .tc(c1_tc), .ovf(c1_ovf), .load_err(c1_lerr));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference rules written as plain modular / clamped arithmetic on integers
  task automatic modelStep(input int modulus, input bit sat, input int q_in,
                           output int q_out, output bit o, output bit le);
    int max = modulus - 1;
    q_out = q_in; o = 1'b0; le = 1'b0;
    if (reset) q_out = 0;
    else if (load) begin
      le    = (int'(load_val) > max);
      q_out = le ? max : int'(load_val);
    end else if (en && up_dn) begin
      o     = (q_in == max);
      q_out = sat ? ((q_in + 1 > max) ? max : q_in + 1) : (q_in + 1) % modulus;
    end else if (en) begin
      o     = (q_in == 0);
      q_out = sat ? ((q_in == 0) ? 0 : q_in - 1) : (q_in + modulus - 1) % modulus;
    end
  endtask

  function automatic bit expectedTc(input int modulus, input int q);
    return en && ((up_dn && q == modulus - 1) || (!up_dn && q == 0));
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l, input logic [3:0] lv);
    reset = r; en = e; up_dn = u; load = l; load_val = lv;
    #1;
    if (started) begin
      checkOutput("a_tc", a_tc, expectedTc(10, qa));
      checkOutput("b_tc", b_tc, expectedTc(16, qb));
    end
    modelStep(10, 1'b0, qa, qa, oa, la);
    modelStep(16, 1'b1, qb, qb, ob, lb);
    @(posedge clk);
    #1;
    started = 1'b1;
    checkOutput("a_q", a_q, qa);
    checkOutput("a_ovf", a_ovf, oa);
    checkOutput("a_load_err", a_lerr, la);
    checkOutput("b_q", b_q, qb);
    checkOutput("b_ovf", b_ovf, ob);
    checkOutput("b_load_err", b_lerr, lb);
  endtask

  initial begin
    int n;
    c_reset = 1'b1; c_en = 1'b0;

    // Reset state
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("reset_a_q", a_q, 0);

    // Up count with wrap through 9 -> 0
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("up_seq_a_q", a_q, (i + 1) % 10);
      checkOutput("up_seq_a_ovf", a_ovf, (i == 9) ? 1 : 0);
    end

    // Down count with wrap 0 -> 9
    applyStimulus(1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("down_seq_a_q", a_q, (19 - i) % 10);
    end

    // Saturation at the top, then immediate reversal
    applyStimulus(0, 0, 1, 1, 4'd14);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("sat_b_q", b_q, 15);
      checkOutput("sat_b_ovf", b_ovf, (i == 0) ? 0 : 1);
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("sat_rev_b_q", b_q, 14);

    // Load wins over en; out-of-range load clamps
    applyStimulus(0, 1, 1, 1, 4'd5);
    checkOutput("load_a_q", a_q, 5);
    applyStimulus(0, 1, 1, 1, 4'd12);
    checkOutput("clamp_a_q", a_q, 9);
    checkOutput("clamp_a_err", a_lerr, 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("clamp_pulse_end", a_lerr, 0);

    // Reset wins over load and en, and clears mid-count
    applyStimulus(1, 1, 1, 1, 4'd7);
    checkOutput("rst_prio_a_q", a_q, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("midcount_a_q", a_q, 6);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("midrst_a_q", a_q, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(31) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
                    ($urandom_range(7) == 0), 4'($urandom_range(15)));

    // Two-digit cascade counting 0..100
    @(negedge clk);
    c_reset = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;
    c_reset = 1'b0; c_en = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      checkOutput("c0_tc", c0_tc, (n % 10 == 9) ? 1 : 0);
      checkOutput("c1_tc", c1_tc, (n % 100 == 99) ? 1 : 0);
      @(posedge clk); #1;
      n++;
      checkOutput("c0_q", c0_q, n % 10);
      checkOutput("c1_q", c1_q, (n / 10) % 10);
      checkOutput("c0_ovf", c0_ovf, (n % 10 == 0) ? 1 : 0);
      checkOutput("c1_ovf", c1_ovf, (n % 100 == 0) ? 1 : 0);
      if (n == 99) checkOutput("cascade_99", {c1_q, c0_q}, 8'h99);
    end
    checkOutput("cascade_wrap", {c1_q, c0_q, 2'b00, c1_ovf, c0_ovf}, 12'h003);
    checkOutput("cascade_no_lerr", {c1_lerr, c0_lerr}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
